cast_out_vc_tracker: RTL and testbench

//  Per-output-port VC state and credit controller. Holds the state of each downstream VC.

---
 rtl/cast_pkg.sv | 13 +
 rtl/cast_vc_credit_counter.sv | 40 ++++
 rtl/cast_out_vc_tracker.sv | 96 +++++++++
 tb/tb_cast_out_vc_tracker.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/cast_pkg.sv
// rtl/cast_pkg.sv - shared VC state type, credit width and error bit indices for the output VC tracker
package cast_pkg;

  typedef enum logic [1:0] {VC_IDLE, VC_ACTIVE, VC_DRAIN} vc_state_t;

  localparam int BUF_DEPTH_DEF = 4;
  localparam int CRED_W        = $clog2(BUF_DEPTH_DEF + 1);

  localparam int ERR_OVF   = 0;
  localparam int ERR_UDF   = 1;
  localparam int ERR_ALLOC = 2;

endpackage

// File: rtl/cast_vc_credit_counter.sv
// rtl/cast_vc_credit_counter.sv - saturating per-VC downstream credit counter with overflow/underflow pulses
module cast_vc_credit_counter #(
  parameter int  DEPTH = 4,
  localparam int W     = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         ovf,
  output logic         udf
);

  localparam logic [W-1:0] FULL = W'(DEPTH);

  logic [W-1:0] count_q, count_d;

  // A simultaneous inc and dec cancels out and can never raise an error.
  always_comb begin
    count_d = count_q;
    ovf     = 1'b0;
    udf     = 1'b0;
    if (inc && !dec) begin
      if (count_q == FULL) ovf = 1'b1;
      else                 count_d = count_q + 1'b1;
    end else if (dec && !inc) begin
      if (count_q == '0) udf = 1'b1;
      else               count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) count_q <= FULL;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/cast_out_vc_tracker.sv
// rtl/cast_out_vc_tracker.sv - per-output-port VC state/credit tracker; WAIT_EMPTY_EN holds a VC in DRAIN until its downstream buffer empties
module cast_out_vc_tracker
  import cast_pkg::*;
#(
  parameter int VC_NUM    = 5,
  parameter int BUF_DEPTH = BUF_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [VC_NUM-1:0] outVCAvailableReset,
  input  logic [VC_NUM-1:0] flitSent,
  input  logic [VC_NUM-1:0] tailSent,
  input  logic [VC_NUM-1:0] creditIn,
  output logic [VC_NUM-1:0] outVCAvailable,
  output logic [VC_NUM-1:0] outVCCreditOk,
  output logic [2:0]        errFlag
);

  localparam int            CW   = $clog2(BUF_DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);

  vc_state_t         state_q [VC_NUM];
  vc_state_t         state_d [VC_NUM];
  logic [VC_NUM-1:0] avail_q, avail_d;
  logic [VC_NUM-1:0] cred_ok_q, cred_ok_d;
  logic [2:0]        err_q, err_d;
  logic [CW-1:0]     cnt [VC_NUM];
  logic [VC_NUM-1:0] ovf, udf, nxt_full, nxt_zero;

  for (genvar g = 0; g < VC_NUM; g++) begin : g_vc
    cast_vc_credit_counter #(.DEPTH(BUF_DEPTH)) u_cred (
      .clk   (clk),
      .rstn  (rstn),
      .inc   (creditIn[g]),
      .dec   (flitSent[g]),
      .count (cnt[g]),
      .ovf   (ovf[g]),
      .udf   (udf[g])
    );
    // Next-cycle credit predicates, including saturation at both ends.
    assign nxt_full[g] = ((cnt[g] == FULL) && !(flitSent[g] && !creditIn[g])) ||
                         ((cnt[g] == FULL - 1'b1) && creditIn[g] && !flitSent[g]);
    assign nxt_zero[g] = ((cnt[g] == '0) && !(creditIn[g] && !flitSent[g])) ||
                         ((cnt[g] == CW'(1)) && flitSent[g] && !creditIn[g]);
  end

  always_comb begin
    err_d = err_q;
    for (int i = 0; i < VC_NUM; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        VC_IDLE: begin
          if (outVCAvailableReset[i]) state_d[i] = VC_ACTIVE;
        end
        VC_ACTIVE: begin
          if (outVCAvailableReset[i]) err_d[ERR_ALLOC] = 1'b1;
          if (flitSent[i] && tailSent[i]) begin
`ifdef WAIT_EMPTY_EN
            state_d[i] = VC_DRAIN;
`else
            state_d[i] = VC_IDLE;
`endif
          end
        end
        VC_DRAIN: begin
          if (outVCAvailableReset[i]) err_d[ERR_ALLOC] = 1'b1;
          if (nxt_full[i]) state_d[i] = VC_IDLE;
        end
        default: state_d[i] = VC_IDLE;
      endcase
      avail_d[i]   = (state_d[i] == VC_IDLE);
      cred_ok_d[i] = !nxt_zero[i];
    end
    if (|ovf) err_d[ERR_OVF] = 1'b1;
    if (|udf) err_d[ERR_UDF] = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < VC_NUM; i++) state_q[i] <= VC_IDLE;
      avail_q   <= '1;
      cred_ok_q <= '1;
      err_q     <= '0;
    end else begin
      for (int i = 0; i < VC_NUM; i++) state_q[i] <= state_d[i];
      avail_q   <= avail_d;
      cred_ok_q <= cred_ok_d;
      err_q     <= err_d;
    end
  end

  assign outVCAvailable = avail_q;
  assign outVCCreditOk  = cred_ok_q;
  assign errFlag        = err_q;

endmodule

// File: tb/tb_cast_out_vc_tracker.sv
// tb/tb_cast_out_vc_tracker.sv - self-checking bench: directed scenarios plus randomized traffic against a behavioural model
module tb_cast_out_vc_tracker;

  localparam int N     = 5;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rstn;
  logic [N-1:0] ovr, fs, ts, ci;
  logic [N-1:0] avail, cok;
  logic [2:0]   err;

  int checks   = 0;
  int failures = 0;

  // Model: per VC, 0 = free, 1 = carrying a packet, 2 = waiting for an empty buffer.
  int       m_st   [N];
  int       m_cred [N];
  bit [2:0] m_err;

  cast_out_vc_tracker #(.VC_NUM(N), .BUF_DEPTH(DEPTH)) dut (
    .clk                 (clk),
    .rstn                (rstn),
    .outVCAvailableReset (ovr),
    .flitSent            (fs),
    .tailSent            (ts),
    .creditIn            (ci),
    .outVCAvailable      (avail),
    .outVCCreditOk       (cok),
    .errFlag             (err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_st[i]   = 0;
      m_cred[i] = DEPTH;
    end
    m_err = '0;
  endtask

  task automatic model_step();
    for (int i = 0; i < N; i++) begin
      if (fs[i] && !ci[i]) begin
        if (m_cred[i] == 0) m_err[1] = 1'b1;
        else                m_cred[i] = m_cred[i] - 1;
      end else if (ci[i] && !fs[i]) begin
        if (m_cred[i] == DEPTH) m_err[0] = 1'b1;
        else                    m_cred[i] = m_cred[i] + 1;
      end
      if (m_st[i] == 0) begin
        if (ovr[i]) m_st[i] = 1;
      end else begin
        if (ovr[i]) m_err[2] = 1'b1;
        if (m_st[i] == 1 && fs[i] && ts[i]) begin
`ifdef WAIT_EMPTY_EN
          m_st[i] = 2;
`else
          m_st[i] = 0;
`endif
        end else if (m_st[i] == 2 && m_cred[i] == DEPTH) begin
          m_st[i] = 0;
        end
      end
    end
  endtask

  function automatic logic [N-1:0] m_avail();
    for (int i = 0; i < N; i++) m_avail[i] = (m_st[i] == 0);
  endfunction

  function automatic logic [N-1:0] m_cok();
    for (int i = 0; i < N; i++) m_cok[i] = (m_cred[i] != 0);
  endfunction

  task automatic idle_in();
    ovr = '0; fs = '0; ts = '0; ci = '0;
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_in();
    rstn = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (avail !== 5'b11111) begin failures++; $display("FAIL reset_avail got=%b exp=11111", avail); end
    checks++; if (cok !== 5'b11111)   begin failures++; $display("FAIL reset_cok got=%b exp=11111", cok); end
    checks++; if (err !== 3'b000)     begin failures++; $display("FAIL reset_err got=%b exp=000", err); end
  endtask

  task automatic test_alloc_tail();
    do_reset();
    ovr = 5'b00100; cyc(); idle_in();
    checks++; if (avail !== 5'b11011) begin failures++; $display("FAIL alloc_avail got=%b exp=11011", avail); end
    fs = 5'b00100; cyc(); cyc();
    ts = 5'b00100; cyc(); idle_in();
`ifdef WAIT_EMPTY_EN
    checks++; if (avail !== 5'b11011) begin failures++; $display("FAIL tail_avail got=%b exp=11011", avail); end
    ci = 5'b00100; cyc(); cyc();
    checks++; if (avail !== 5'b11011) begin failures++; $display("FAIL drain_avail got=%b exp=11011", avail); end
    cyc(); idle_in();
    checks++; if (avail !== 5'b11111) begin failures++; $display("FAIL drain_done got=%b exp=11111", avail); end
`else
    checks++; if (avail !== 5'b11111) begin failures++; $display("FAIL tail_avail got=%b exp=11111", avail); end
    ci = 5'b00100; cyc(); cyc(); cyc(); idle_in();
    checks++; if (avail !== 5'b11111) begin failures++; $display("FAIL credit_back_avail got=%b exp=11111", avail); end
`endif
    checks++; if (err !== 3'b000) begin failures++; $display("FAIL alloc_tail_err got=%b exp=000", err); end
  endtask

  task automatic test_credit();
    do_reset();
    fs = 5'b00001; cyc(); cyc(); cyc();
    checks++; if (cok[0] !== 1'b1) begin failures++; $display("FAIL cred_one_left got=%b exp=1", cok[0]); end
    cyc();
    checks++; if (cok[0] !== 1'b0) begin failures++; $display("FAIL cred_zero got=%b exp=0", cok[0]); end
    checks++; if (err !== 3'b000)  begin failures++; $display("FAIL cred_zero_err got=%b exp=000", err); end
    cyc();
    checks++; if (err !== 3'b010)  begin failures++; $display("FAIL udf_err got=%b exp=010", err); end
    checks++; if (cok[0] !== 1'b0) begin failures++; $display("FAIL udf_cok got=%b exp=0", cok[0]); end
    ci = 5'b00001; cyc();
    checks++; if (cok[0] !== 1'b0) begin failures++; $display("FAIL both_cok got=%b exp=0", cok[0]); end
    fs = '0; cyc(); idle_in();
    checks++; if (cok[0] !== 1'b1) begin failures++; $display("FAIL one_credit_cok got=%b exp=1", cok[0]); end
    checks++; if (err !== 3'b010)  begin failures++; $display("FAIL sticky_udf got=%b exp=010", err); end
  endtask

  task automatic test_alloc_err();
    do_reset();
    ovr = 5'b00010; cyc(); idle_in();
    cyc(); cyc();
    checks++; if (err !== 3'b000) begin failures++; $display("FAIL first_alloc_err got=%b exp=000", err); end
    ovr = 5'b00010; cyc(); idle_in();
    checks++; if (err !== 3'b100)      begin failures++; $display("FAIL illegal_alloc got=%b exp=100", err); end
    checks++; if (avail !== 5'b11101)  begin failures++; $display("FAIL vc1_active got=%b exp=11101", avail); end
    ci = 5'b01000; cyc(); idle_in();
    checks++; if (err !== 3'b101)      begin failures++; $display("FAIL ovf_err got=%b exp=101", err); end
    checks++; if (cok !== 5'b11111)    begin failures++; $display("FAIL ovf_cok got=%b exp=11111", cok); end
  endtask

  task automatic test_async_reset();
    do_reset();
    ovr = 5'b10000; cyc(); idle_in();
    fs = 5'b10000; cyc(); cyc(); cyc(); idle_in();
    ci = 5'b01000; cyc(); idle_in();
    checks++; if (avail !== 5'b01111) begin failures++; $display("FAIL pre_rst_avail got=%b exp=01111", avail); end
    checks++; if (err !== 3'b001)     begin failures++; $display("FAIL pre_rst_err got=%b exp=001", err); end
    #2 rstn = 1'b0;
    #1;
    checks++; if (avail !== 5'b11111) begin failures++; $display("FAIL async_avail got=%b exp=11111", avail); end
    checks++; if (cok !== 5'b11111)   begin failures++; $display("FAIL async_cok got=%b exp=11111", cok); end
    checks++; if (err !== 3'b000)     begin failures++; $display("FAIL async_err got=%b exp=000", err); end
    @(posedge clk); #1;
    rstn = 1'b1;
    model_reset();
    fs = 5'b10000; cyc(); cyc(); cyc();
    checks++; if (cok[4] !== 1'b1) begin failures++; $display("FAIL post_rst_cred3 got=%b exp=1", cok[4]); end
    cyc(); idle_in();
    checks++; if (cok[4] !== 1'b0) begin failures++; $display("FAIL post_rst_cred4 got=%b exp=0", cok[4]); end
  endtask

  task automatic test_random();
    logic [N-1:0] ea, ec;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        ovr[i] = ($urandom_range(0, 9) == 0);
        fs[i]  = ($urandom_range(0, 2) == 0);
        ts[i]  = fs[i] && ($urandom_range(0, 3) == 0);
        ci[i]  = ($urandom_range(0, 2) == 0);
      end
      if (c % 97 == 0) ovr = '0;
      cyc();
      ea = m_avail();
      ec = m_cok();
      checks++; if (avail !== ea) begin failures++; $display("FAIL rnd_avail cyc=%0d got=%b exp=%b", c, avail, ea); end
      checks++; if (cok !== ec)   begin failures++; $display("FAIL rnd_cok cyc=%0d got=%b exp=%b", c, cok, ec); end
      checks++; if (err !== m_err) begin failures++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", c, err, m_err); end
      if (c % 100 == 99) do_reset();
    end
    idle_in();
  endtask

  initial begin
    idle_in();
    rstn = 1'b0;
    model_reset();
    test_reset();
    test_alloc_tail();
    test_credit();
    test_alloc_err();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
